agc_loop: RTL and testbench
===========================

# agc_loop

Closed-loop gain and DC-offset controller for one RF front-end channel. It consumes the per-channel statistics produced upstream: the 2-bit magnitude histogram fraction `h0` and the DC estimate `dc`, both in 1/256 and 1/32-LSB units and held stable for one 2^19-cycle integration period. Once per period it steps a front-end gain code and an ADC offset-trim code, and writes any changed value to the front-end DAC over a 3-wire serial link.

## Interface
Parameters:
- `PERIOD_LOG2`, 19: log2 of the statistics period in cycles.
- `TARGET`, 8'd85: desired `h0` (outer-level fraction ×256, ≈33%).
- `HYST`, 8'd6: dead band around `TARGET`.
- `GAIN_INIT`, 6'd32: gain code after reset.
- `GAIN_MAX`, 6'd63: gain ceiling. The floor is 0.
- `DC_SHIFT`, 3: arithmetic right shift applied to `dc` before it is applied to the offset.
- `SPI_DIV`, 4: clk cycles per half `spi_sclk` period, minimum 1.

Ports:
- `clk` in 1: sample clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `h0` in 8: outer-level count fraction.
- `dc` in 8: signed DC estimate.
- `hold` in 1: freezes both loops. Frames already in progress still complete.
- `gain` out 6: current gain code.
- `offset` out 8: current signed offset-trim code.
- `spi_cs_n` out 1: frame select, active-low.
- `spi_sclk` out 1: serial clock, idle low.
- `spi_mosi` out 1: serial data, MSB first.
- `busy` out 1: high while a frame is in flight.
- `overrun` out 1: sticky flag, set when a sample point arrives while `busy` is high.

## Operation
- A free-running counter of `PERIOD_LOG2` bits wraps each period.
  - The sample point is count == 2^(PERIOD_LOG2-1), i.e. mid-period, so sampling is independent of the upstream dump phase.
- FSM states: IDLE, CALC, SEND_GAIN, SEND_OFS.
  - IDLE → CALC at a sample point. `h0` and `dc` are registered in that same cycle.
  - CALC lasts 1 cycle.
  - CALC → SEND_GAIN if the gain changed or `force` is set.
  - Otherwise CALC → SEND_OFS if the offset changed or `force` is set.
  - Otherwise CALC → IDLE.
  - SEND_GAIN → SEND_OFS (subject to the same condition) or IDLE.
  - SEND_OFS → IDLE.
- Gain law (skipped when `hold` is high):
  - `h0` > `TARGET`+`HYST`: gain−1, saturating at 0.
  - `h0` < `TARGET`−`HYST`: gain+1, saturating at `GAIN_MAX`.
  - Otherwise: unchanged.
  - Compare in 9 bits so `TARGET`±`HYST` cannot wrap.
- Offset law (skipped when `hold` is high): offset ← sat8(offset − (dc >>> `DC_SHIFT`)). Compute in 9-bit signed, then clamp to [−128, 127].
- `force` is set by reset and cleared after the first CALC. The first sample point after reset therefore always sends both frames.
- Frame format (16 bits): [15:12] address, [11:8] 0, [7:0] data.
  - Gain frame: address 4'h1, data {2'b0, gain}.
  - Offset frame: address 4'h2, data = offset.
- Sample point while `busy` is high: that sample is skipped, `overrun` ← 1, and loop state is unchanged. `overrun` is cleared only by reset.

## Timing
- Reset values:
  - `gain` = `GAIN_INIT`, `offset` = 0.
  - `spi_cs_n` = 1, `spi_sclk` = 0, `spi_mosi` = 0.
  - `busy` = 0, `overrun` = 0.
  - Period counter = 0, FSM = IDLE.
- Reset is asynchronous mid-frame: all outputs return immediately to their reset values, and the partial frame is abandoned.
- `gain` and `offset` update at the end of the CALC cycle, i.e. 2 cycles after the sample point.
- Frame timing:
  - `spi_cs_n` falls in the cycle after CALC.
  - `spi_mosi` is valid `SPI_DIV` cycles before each `spi_sclk` rising edge and changes only while `spi_sclk` is low.
  - 16 rising edges per frame.
  - `spi_cs_n` rises `SPI_DIV` cycles after the last falling edge.
  - Minimum `spi_cs_n`-high gap between back-to-back frames: 2·`SPI_DIV` cycles.
- `busy` = !`spi_cs_n` OR (FSM in a SEND state).

## Configuration
- `AGC_DC_TRIM_EN` defined: offset loop and offset frame are present as described above.
- `AGC_DC_TRIM_EN` undefined: `dc` is ignored, `offset` is held at 0, SEND_OFS is never entered, and only gain frames are sent (including the forced first frame).

## Structure
- Package `agc_pkg`:
  - FSM state enum.
  - Address constants `AGC_ADDR_GAIN` = 4'h1 and `AGC_ADDR_OFS` = 4'h2.
  - Frame width constant 16.
  - Saturating add helper.
- Sub-module `spi_tx16`: 16-bit shifter, start/busy handshake, `SPI_DIV` divider. It accepts `start` only when idle.
- `agc_loop` holds the period counter, the loops, and the FSM.

## Test plan
- Reset release with `h0`=85, `dc`=0 (`PERIOD_LOG2`=8, `SPI_DIV`=1):
  - First sample point (count 128) sends frames 0x1020 and then 0x2000.
  - No frames are sent in later periods.
- `h0`=120 held for 40 periods from gain 32:
  - Gain decrements by 1 per period and saturates at 0.
  - Each decrement sends exactly one gain frame, with the correct data on `spi_mosi`.
- `h0`=10 held: gain climbs to 63, then stays at 63, and frames stop once saturated.
- `dc`=8'h80 (−128) with `DC_SHIFT`=3:
  - Offset steps +16 per period and clamps at 127.
  - With the macro undefined, offset stays 0 and no 0x2xxx frame ever appears.
- Overrun: `SPI_DIV`=8, `PERIOD_LOG2`=8, with both values changing each period. `overrun` asserts and that sample's loop update is skipped.
- Assert `reset_n` low at bit 7 of a frame:
  - `spi_cs_n`=1 and `spi_sclk`=0 asynchronously.
  - After release, the first sample point re-sends both forced frames.

Source files
------------

// File: rtl/agc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : agc_pkg
//  Purpose  : Shared types, frame constants and saturating arithmetic for
//             the AGC / DC-offset controller and its serial DAC transmitter.
//  Revision : 1.0  initial release
// ============================================================================
package agc_pkg;

  // Loop sequencer states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CALC      = 2'd1,
    ST_SEND_GAIN = 2'd2,
    ST_SEND_OFS  = 2'd3
  } agc_state_e;

  // Serial transmitter phases
  typedef enum logic [2:0] {
    SPI_IDLE = 3'd0,
    SPI_LOW  = 3'd1,
    SPI_HIGH = 3'd2,
    SPI_TAIL = 3'd3,
    SPI_GAP  = 3'd4
  } spi_phase_e;

  localparam logic [3:0] AGC_ADDR_GAIN = 4'h1;
  localparam logic [3:0] AGC_ADDR_OFS  = 4'h2;
  localparam int         AGC_FRAME_W   = 16;

  // a + b evaluated in 9-bit signed, clamped to the 8-bit signed range.
  // Operand ranges keep the 9-bit sum itself from wrapping.
  function automatic logic signed [7:0] sat_add8(input logic signed [7:0] a,
                                                 input logic signed [8:0] b);
    logic signed [8:0] s;
    s = {a[7], a} + b;
    if (s > 9'sd127) begin
      return 8'sd127;
    end else if (s < -9'sd128) begin
      return -8'sd128;
    end
    return $signed(s[7:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/agc_loop_spi_tx16.sv
`default_nettype none
// ============================================================================
//  Module   : spi_tx16
//  Purpose  : 16-bit MSB-first 3-wire transmitter. SPI_DIV clk cycles per
//             half sclk period; MOSI set up a half period before each rising
//             edge, CS held a half period after the last falling edge, then
//             a 2*SPI_DIV idle gap before the next start is accepted.
//  Revision : 1.0  initial release
// ============================================================================
module spi_tx16
  import agc_pkg::*;
#(
  parameter int SPI_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [AGC_FRAME_W-1:0] data,
  output logic                   busy,
  output logic                   spi_cs_n,
  output logic                   spi_sclk,
  output logic                   spi_mosi
);

  localparam int             CNT_W    = $clog2(2 * SPI_DIV + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SPI_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2 * SPI_DIV - 1);

  spi_phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]       div_q, div_d;
  logic [3:0]             bit_q, bit_d;
  logic [AGC_FRAME_W-1:0] shreg_q, shreg_d;
  logic                   cs_n_q, cs_n_d;
  logic                   sclk_q, sclk_d;
  logic                   mosi_q, mosi_d;

  // Phase sequencing: each phase lasts one divider terminal count
  always_comb begin
    phase_d = phase_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    case (phase_q)
      SPI_IDLE: begin
        if (start) begin
          phase_d = SPI_LOW;
          div_d   = '0;
          bit_d   = 4'd0;
          shreg_d = data;
          cs_n_d  = 1'b0;
          mosi_d  = data[AGC_FRAME_W-1];
        end
      end
      SPI_LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          phase_d = SPI_HIGH;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      SPI_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 4'd15) begin
            phase_d = SPI_TAIL;
          end else begin
            // next bit goes out on the falling edge, i.e. while sclk is low
            bit_d   = bit_q + 4'd1;
            shreg_d = {shreg_q[AGC_FRAME_W-2:0], 1'b0};
            mosi_d  = shreg_q[AGC_FRAME_W-2];
            phase_d = SPI_LOW;
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      SPI_TAIL: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          phase_d = SPI_GAP;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      SPI_GAP: begin
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          phase_d = SPI_IDLE;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      default: begin
        phase_d = SPI_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // Transmitter registers; reset abandons any partial frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= SPI_IDLE;
      div_q   <= '0;
      bit_q   <= 4'd0;
      shreg_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign busy     = (phase_q != SPI_IDLE);
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

endmodule
`default_nettype wire

// File: rtl/agc_loop.sv
`default_nettype none
// ============================================================================
//  Module   : agc_loop
//  Purpose  : Once-per-period gain and DC-offset trim controller. Samples the
//             upstream statistics mid-period, steps the gain/offset codes and
//             writes changed codes to the front-end DAC over spi_tx16.
//  Config   : AGC_DC_TRIM_EN enables the offset loop and offset frames.
//  Revision : 1.0  initial release
// ============================================================================
module agc_loop
  import agc_pkg::*;
#(
  parameter int         PERIOD_LOG2 = 19,
  parameter logic [7:0] TARGET      = 8'd85,
  parameter logic [7:0] HYST        = 8'd6,
  parameter logic [5:0] GAIN_INIT   = 6'd32,
  parameter logic [5:0] GAIN_MAX    = 6'd63,
  parameter int         DC_SHIFT    = 3,
  parameter int         SPI_DIV     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] h0,
  input  logic [7:0] dc,
  input  logic       hold,
  output logic [5:0] gain,
  output logic [7:0] offset,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       busy,
  output logic       overrun
);

  // Mid-period sample point, independent of the upstream dump phase
  localparam logic [PERIOD_LOG2-1:0] SAMPLE_PT = {1'b1, {(PERIOD_LOG2-1){1'b0}}};
  localparam logic [8:0] H0_HI = {1'b0, TARGET} + {1'b0, HYST};
  localparam logic [8:0] H0_LO = {1'b0, TARGET} - {1'b0, HYST};

  logic [PERIOD_LOG2-1:0] cnt_q, cnt_d;
  agc_state_e             state_q, state_d;
  logic [7:0]             h0_q, h0_d;
  logic [5:0]             gain_q, gain_d;
  logic signed [7:0]      ofs_q, ofs_d;
  logic                   force_q, force_d;
  logic                   ofs_pend_q, ofs_pend_d;
  logic                   overrun_q, overrun_d;

  logic                   sample_pt;
  logic                   busy_now;
  logic [5:0]             gain_new;
  logic signed [7:0]      ofs_new;
  logic                   gain_send;
  logic                   ofs_send;
  logic                   spi_start;
  logic [AGC_FRAME_W-1:0] spi_data;
  logic                   spi_busy;

  assign sample_pt = (cnt_q == SAMPLE_PT);
  assign busy_now  = !spi_cs_n || (state_q == ST_SEND_GAIN) || (state_q == ST_SEND_OFS);

  // Gain law on the registered h0, with 9-bit thresholds
  always_comb begin
    gain_new = gain_q;
    if (!hold) begin
      if ({1'b0, h0_q} > H0_HI) begin
        gain_new = (gain_q == 6'd0) ? 6'd0 : gain_q - 6'd1;
      end else if ({1'b0, h0_q} < H0_LO) begin
        gain_new = (gain_q >= GAIN_MAX) ? GAIN_MAX : gain_q + 6'd1;
      end
    end
  end
  assign gain_send = (gain_new != gain_q) || force_q;

`ifdef AGC_DC_TRIM_EN
  logic [7:0]        dc_q, dc_d;
  logic signed [7:0] dc_sh;
  logic signed [8:0] dc_neg;

  // Offset law: subtract the scaled DC estimate, saturating to 8 bits
  always_comb begin
    dc_sh   = $signed(dc_q) >>> DC_SHIFT;
    dc_neg  = -$signed({dc_sh[7], dc_sh});
    ofs_new = hold ? ofs_q : sat_add8(ofs_q, dc_neg);
  end
  assign ofs_send = (ofs_new != ofs_q) || force_q;
  assign dc_d     = (state_q == ST_IDLE && sample_pt && !busy_now) ? dc : dc_q;

  // DC estimate capture register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dc_q <= 8'd0;
    end else begin
      dc_q <= dc_d;
    end
  end
`else
  // Offset trim absent: the DC estimate is deliberately ignored
  logic dc_unused;
  assign dc_unused = ^dc;
  assign ofs_new   = 8'sd0;
  assign ofs_send  = 1'b0;
`endif

  // Period counter, loop registers, overrun flag and frame sequencing
  always_comb begin
    cnt_d      = cnt_q + PERIOD_LOG2'(1);
    state_d    = state_q;
    h0_d       = h0_q;
    gain_d     = gain_q;
    ofs_d      = ofs_q;
    force_d    = force_q;
    ofs_pend_d = ofs_pend_q;
    overrun_d  = overrun_q;
    spi_start  = 1'b0;
    spi_data   = '0;
    if (sample_pt && busy_now) begin
      overrun_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (sample_pt && !busy_now) begin
          h0_d    = h0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        gain_d     = gain_new;
        ofs_d      = ofs_new;
        force_d    = 1'b0;
        ofs_pend_d = ofs_send;
        if (gain_send) begin
          spi_start = 1'b1;
          spi_data  = {AGC_ADDR_GAIN, 4'h0, 2'b00, gain_new};
          state_d   = ST_SEND_GAIN;
        end else if (ofs_send) begin
          spi_start  = 1'b1;
          spi_data   = {AGC_ADDR_OFS, 4'h0, ofs_new};
          ofs_pend_d = 1'b0;
          state_d    = ST_SEND_OFS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_GAIN: begin
        // transmitter idle also covers its inter-frame CS-high gap
        if (!spi_busy) begin
          if (ofs_pend_q) begin
            spi_start  = 1'b1;
            spi_data   = {AGC_ADDR_OFS, 4'h0, ofs_q};
            ofs_pend_d = 1'b0;
            state_d    = ST_SEND_OFS;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SEND_OFS: begin
        if (!spi_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      h0_q       <= 8'd0;
      gain_q     <= GAIN_INIT;
      ofs_q      <= 8'sd0;
      force_q    <= 1'b1;
      ofs_pend_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      h0_q       <= h0_d;
      gain_q     <= gain_d;
      ofs_q      <= ofs_d;
      force_q    <= force_d;
      ofs_pend_q <= ofs_pend_d;
      overrun_q  <= overrun_d;
    end
  end

  spi_tx16 #(
    .SPI_DIV (SPI_DIV)
  ) u_spi (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (spi_start),
    .data     (spi_data),
    .busy     (spi_busy),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi)
  );

  assign gain    = gain_q;
  assign offset  = ofs_q;
  assign busy    = busy_now;
  assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_agc_loop.sv
`default_nettype none
// ============================================================================
//  Module   : tb_agc_loop
//  Purpose  : Self-checking bench for agc_loop. Two instances share inputs:
//             u_fast (SPI_DIV=1) never overruns and has its frames decoded
//             and scoreboarded; u_slow (SPI_DIV=8) overruns every period that
//             follows a frame. A behavioural model predicts codes, frames
//             and overrun from the control laws.
//  Config   : honours AGC_DC_TRIM_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_agc_loop;

  localparam int PL2    = 8;
  localparam int PERIOD = 1 << PL2;
  localparam int SAMPLE = PERIOD / 2;
  localparam int NDUT   = 2;
  localparam int TGT    = 85;
  localparam int HYS    = 6;
  localparam int G_INIT = 32;
  localparam int G_MAX  = 63;
  localparam int SHIFT  = 3;
`ifdef AGC_DC_TRIM_EN
  localparam bit TRIM = 1'b1;
`else
  localparam bit TRIM = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [7:0] h0;
  logic [7:0] dc;
  logic       hold;

  logic [5:0] gain_o   [NDUT];
  logic [7:0] offset_o [NDUT];
  logic       cs_o     [NDUT];
  logic       sclk_o   [NDUT];
  logic       mosi_o   [NDUT];
  logic       busy_o   [NDUT];
  logic       ovr_o    [NDUT];

  agc_loop #(.PERIOD_LOG2(PL2), .TARGET(8'd85), .HYST(8'd6), .GAIN_INIT(6'd32),
             .GAIN_MAX(6'd63), .DC_SHIFT(SHIFT), .SPI_DIV(1)) u_fast (
    .clk(clk), .reset_n(reset_n), .h0(h0), .dc(dc), .hold(hold),
    .gain(gain_o[0]), .offset(offset_o[0]), .spi_cs_n(cs_o[0]), .spi_sclk(sclk_o[0]),
    .spi_mosi(mosi_o[0]), .busy(busy_o[0]), .overrun(ovr_o[0]));

  agc_loop #(.PERIOD_LOG2(PL2), .TARGET(8'd85), .HYST(8'd6), .GAIN_INIT(6'd32),
             .GAIN_MAX(6'd63), .DC_SHIFT(SHIFT), .SPI_DIV(8)) u_slow (
    .clk(clk), .reset_n(reset_n), .h0(h0), .dc(dc), .hold(hold),
    .gain(gain_o[1]), .offset(offset_o[1]), .spi_cs_n(cs_o[1]), .spi_sclk(sclk_o[1]),
    .spi_mosi(mosi_o[1]), .busy(busy_o[1]), .overrun(ovr_o[1]));

  int errors = 0;
  int checks = 0;

  // behavioural model state
  longint      cyc = 0;
  int          tb_cnt = 0;
  int          m_gain [NDUT];
  int          m_ofs  [NDUT];
  bit          m_force[NDUT];
  bit          m_ovr  [NDUT];
  longint      busy_until[NDUT];
  int          since  [NDUT];
  int          pre_g  [NDUT];
  int          pre_o  [NDUT];
  logic [15:0] exp_q[$];
  int          mon_bits = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 8;
  endfunction

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_gain[i] = G_INIT;
      m_ofs[i] = 0;
      m_force[i] = 1'b1;
      m_ovr[i] = 1'b0;
      busy_until[i] = 0;
      since[i] = 3;
      pre_g[i] = G_INIT;
      pre_o[i] = 0;
    end
    exp_q.delete();
  endfunction

  // One sample point: apply the control laws, predict frames and link occupancy
  function automatic void do_sample(input int i);
    int ng, no, sh, n, d;
    pre_g[i] = m_gain[i];
    pre_o[i] = m_ofs[i];
    since[i] = 1;
    if (cyc < busy_until[i]) begin
      m_ovr[i] = 1'b1;
      return;
    end
    ng = m_gain[i];
    no = m_ofs[i];
    if (!hold) begin
      if (int'(h0) > TGT + HYS) ng = (ng > 0) ? ng - 1 : 0;
      else if (int'(h0) < TGT - HYS) ng = (ng < G_MAX) ? ng + 1 : G_MAX;
      if (TRIM) begin
        sh = int'($signed(dc)) >>> SHIFT;
        no = no - sh;
        if (no > 127) no = 127;
        if (no < -128) no = -128;
      end
    end
    n = 0;
    if (ng != m_gain[i] || m_force[i]) begin
      if (i == 0) exp_q.push_back({4'h1, 4'h0, 2'b00, 6'(ng)});
      n++;
    end
    if (TRIM && (no != m_ofs[i] || m_force[i])) begin
      if (i == 0) exp_q.push_back({4'h2, 4'h0, 8'(no)});
      n++;
    end
    m_force[i] = 1'b0;
    m_gain[i] = ng;
    m_ofs[i] = no;
    d = div_of(i);
    // each frame: 33 half-periods with CS low; 2*div+1 CS-high cycles between
    // frames; 2*div idle gap after the last one
    if (n > 0) busy_until[i] = cyc + 2 + n * 33 * d + (n - 1) * (2 * d + 1) + 2 * d;
  endfunction

  // Model stepping on the active edge
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NDUT; i++) if (since[i] < 3) since[i]++;
      if (!reset_n) begin
        tb_cnt = 0;
        model_reset();
      end else begin
        if (tb_cnt == SAMPLE) for (int i = 0; i < NDUT; i++) do_sample(i);
        tb_cnt = (tb_cnt + 1) % PERIOD;
      end
    end
  end

  // Code/flag checker: old codes one cycle after the sample, new codes after two
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        for (int i = 0; i < NDUT; i++) begin
          if (since[i] == 1) begin
            chk($sformatf("gain_hold_d%0d", i), gain_o[i], pre_g[i]);
            chk($sformatf("ofs_hold_d%0d", i), offset_o[i], 8'(pre_o[i]));
          end else if (since[i] == 2) begin
            chk($sformatf("gain_upd_d%0d", i), gain_o[i], m_gain[i]);
            chk($sformatf("ofs_upd_d%0d", i), offset_o[i], 8'(m_ofs[i]));
            chk($sformatf("overrun_d%0d", i), ovr_o[i], m_ovr[i]);
          end
        end
      end
    end
  end

  // Frame monitor for u_fast: decode MOSI at sclk rises, compare at CS rise
  initial begin
    logic [15:0] shv;
    logic [15:0] e;
    logic        prev_s;
    logic        prev_cs;
    shv = '0;
    prev_s = 1'b0;
    prev_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_bits = 0;
        prev_s = 1'b0;
        prev_cs = 1'b1;
      end else begin
        if (!cs_o[0] && sclk_o[0] && !prev_s) begin
          shv = {shv[14:0], mosi_o[0]};
          mon_bits++;
        end
        if (cs_o[0] && !prev_cs) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected got=%h bits=%0d", shv, mon_bits);
          end else begin
            e = exp_q.pop_front();
            chk("frame_bits", mon_bits, 16);
            chk($sformatf("frame_data_exp_%h", e), shv, e);
          end
          mon_bits = 0;
        end
        prev_s = sclk_o[0];
        prev_cs = cs_o[0];
      end
    end
  end

  task automatic run(input int n, input logic [7:0] hv, input logic [7:0] dv, input logic hl);
    h0 = hv;
    dc = dv;
    hold = hl;
    repeat (n * PERIOD) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gain"}, gain_o[0], G_INIT);
    chk({tag, "_offset"}, offset_o[0], 0);
    chk({tag, "_cs_n"}, cs_o[0], 1);
    chk({tag, "_sclk"}, sclk_o[0], 0);
    chk({tag, "_mosi"}, mosi_o[0], 0);
    chk({tag, "_busy"}, busy_o[0], 0);
    chk({tag, "_overrun_fast"}, ovr_o[0], 0);
    chk({tag, "_overrun_slow"}, ovr_o[1], 0);
  endtask

  initial begin
    bit found;
    reset_n = 1'b0;
    h0 = 8'd85;
    dc = 8'd0;
    hold = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_state("rst");
    reset_n = 1'b1;

    // steady input: only the forced first frames
    run(3, 8'd85, 8'd0, 1'b0);
    // strong signal: gain walks down to the floor
    run(40, 8'd120, 8'd0, 1'b0);
    // weak signal: gain climbs to the ceiling
    run(70, 8'd10, 8'd0, 1'b0);
    // large negative DC: offset climbs and clamps
    run(12, 8'd85, 8'h80, 1'b0);
    // random statistics and hold
    for (int k = 0; k < 20; k++) begin
      run(1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // abandon a frame mid-flight with an asynchronous reset
    h0 = (m_gain[0] > 0) ? 8'd120 : 8'd10;
    dc = 8'd0;
    hold = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 3 * PERIOD && !found; k++) begin
      @(negedge clk);
      #1;
      if (mon_bits == 7 && !cs_o[0]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midframe_wait got=timeout exp=bit7");
    end
    reset_n = 1'b0;
    #1;
    chk_reset_state("async");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run(3, 8'd85, 8'd0, 1'b0);

    repeat (PERIOD) @(negedge clk);
    chk("frames_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
